// File: rtl/midi_message_parser.sv
// Byte-level MIDI channel-message parser: decodes Note On/Off and Control Change
// from a UART byte stream and emits registered voice-update values and strobes.
module midi_message_parser #(
    parameter logic [3:0] CHANNEL = 4'd0,
    parameter bit         OMNI    = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [13:0] note_values,
    output logic [13:0] controller_values,
    output logic        update_voice,
    output logic        update_all_voices,
    output logic        parse_error
);

    localparam int unsigned DATA_W = 7;
    localparam int unsigned VAL_W  = 2 * DATA_W;
    localparam int unsigned SKIP_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA1 = 2'd1,
        DATA2 = 2'd2,
        SYSEX = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          status_q, status_d;
    logic                status_valid_q, status_valid_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [DATA_W-1:0]   d1_q, d1_d;
    logic [VAL_W-1:0]    note_q, note_d;
    logic [VAL_W-1:0]    ctrl_q, ctrl_d;
    logic                update_voice_q, update_voice_d;
    logic                update_all_q, update_all_d;
    logic                parse_error_q, parse_error_d;

    logic                is_data_c, is_realtime_c, is_chan_status_c, is_sys_common_c;
    logic                first_c, second_c, len1_c, complete_c, chan_match_c;
    logic [DATA_W-1:0]   msg_d1_c, msg_d2_c;

    // Byte classification and message-progress helpers
    assign is_data_c        = ~byte_data[7];
    assign is_realtime_c    = (byte_data[7:3] == 5'b11111);
    assign is_chan_status_c = byte_data[7] && (byte_data[7:4] != 4'hF);
    assign is_sys_common_c  = (byte_data[7:4] == 4'hF) && !is_realtime_c;
    assign len1_c           = (status_q[7:5] == 3'b110);
    assign chan_match_c     = OMNI || (status_q[3:0] == CHANNEL);

    assign first_c  = byte_valid && is_data_c && status_valid_q &&
                      (((state_q == IDLE) && (skip_q == '0)) || (state_q == DATA1));
    assign second_c = byte_valid && is_data_c && status_valid_q && (state_q == DATA2);
    assign complete_c = (first_c && len1_c) || second_c;
    assign msg_d1_c   = second_c ? d1_q : byte_data[6:0];
    assign msg_d2_c   = byte_data[6:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            status_q       <= '0;
            status_valid_q <= 1'b0;
            skip_q         <= '0;
            d1_q           <= '0;
            note_q         <= '0;
            ctrl_q         <= '0;
            update_voice_q <= 1'b0;
            update_all_q   <= 1'b0;
            parse_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            status_q       <= status_d;
            status_valid_q <= status_valid_d;
            skip_q         <= skip_d;
            d1_q           <= d1_d;
            note_q         <= note_d;
            ctrl_q         <= ctrl_d;
            update_voice_q <= update_voice_d;
            update_all_q   <= update_all_d;
            parse_error_q  <= parse_error_d;
        end
    end

    // Next-state: realtime bytes never move the FSM
    always_comb begin
        state_d = state_q;
        if (byte_valid && !is_realtime_c) begin
            if (is_chan_status_c) begin
                state_d = DATA1;
            end else if (is_sys_common_c) begin
                state_d = (byte_data == 8'hF0) ? SYSEX : IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (first_c) state_d = len1_c ? DATA1 : DATA2;
                    DATA1:   if (first_c) state_d = len1_c ? DATA1 : DATA2;
                    DATA2:   if (second_c) state_d = DATA1;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // Running status, data latches and registered outputs
    always_comb begin
        status_d       = status_q;
        status_valid_d = status_valid_q;
        skip_d         = skip_q;
        d1_d           = d1_q;
        note_d         = note_q;
        ctrl_d         = ctrl_q;
        update_voice_d = 1'b0;
        update_all_d   = 1'b0;
        parse_error_d  = 1'b0;

        if (byte_valid && is_chan_status_c) begin
            status_d       = byte_data;
            status_valid_d = 1'b1;
            skip_d         = '0;
        end else if (byte_valid && is_sys_common_c) begin
            status_valid_d = 1'b0;
            case (byte_data)
                8'hF1, 8'hF3: skip_d = SKIP_W'(1);
                8'hF2:        skip_d = SKIP_W'(2);
                default:      skip_d = '0;
            endcase
        end else if (byte_valid && is_data_c && (state_q == IDLE)) begin
            // Data bytes owed to F1/F2/F3 are swallowed silently
            if (skip_q != '0) begin
                skip_d = skip_q - SKIP_W'(1);
            end else if (!status_valid_q) begin
                parse_error_d = 1'b1;
            end
        end

        if (first_c) begin
            d1_d = byte_data[6:0];
        end

        if (complete_c && chan_match_c) begin
            case (status_q[7:4])
                4'h9: begin
                    note_d         = {msg_d2_c, msg_d1_c};
                    update_voice_d = 1'b1;
                end
                4'h8: begin
                    note_d         = {DATA_W'(0), msg_d1_c};
                    update_voice_d = 1'b1;
                end
                4'hB: begin
                    ctrl_d         = {msg_d2_c, msg_d1_c};
                    update_voice_d = 1'b1;
                    update_all_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign note_values       = note_q;
    assign controller_values = ctrl_q;
    assign update_voice      = update_voice_q;
    assign update_all_voices = update_all_q;
    assign parse_error       = parse_error_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for midi_message_parser (CHANNEL=0, OMNI=0) with hand-computed values.
module tb_midi_message_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [13:0] note_values;
    logic [13:0] controller_values;
    logic        update_voice;
    logic        update_all_voices;
    logic        parse_error;

    int checks   = 0;
    int failures = 0;
    int uv_count = 0;

    midi_message_parser #(.CHANNEL(4'd0), .OMNI(1'b0)) dut (
        .clk               (clk),
        .reset             (reset),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .note_values       (note_values),
        .controller_values (controller_values),
        .update_voice      (update_voice),
        .update_all_voices (update_all_voices),
        .parse_error       (parse_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && update_voice) uv_count++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte for one cycle; returns at the negedge after it was clocked in
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'h00;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_note", 16'(note_values), 16'h0000);
        check("rst_ctrl", 16'(controller_values), 16'h0000);
        check("rst_strobes", {13'd0, update_voice, update_all_voices, parse_error}, 16'h0000);
        reset = 1'b1;
        idle_cycle();

        // 1: Note On 90 1D 7F
        send(8'h90);
        send(8'h1D);
        check("t1_no_early_strobe", 16'(update_voice), 16'h0000);
        send(8'h7F);
        check("t1_note", 16'(note_values), 16'h3F9D);
        check("t1_uv", 16'(update_voice), 16'h0001);
        check("t1_ua", 16'(update_all_voices), 16'h0000);
        idle_cycle();
        check("t1_uv_width", 16'(update_voice), 16'h0000);

        // 2: running status, back-to-back bytes
        send(8'h1D);
        send(8'h00);
        check("t2a_note", 16'(note_values), 16'h001D);
        check("t2a_uv", 16'(update_voice), 16'h0001);
        send(8'h5B);
        check("t2_uv_drop_continuous", 16'(update_voice), 16'h0000);
        send(8'h40);
        check("t2b_note", 16'(note_values), 16'h205B);
        check("t2b_uv", 16'(update_voice), 16'h0001);
        idle_cycle();

        // 3: Control Change
        send(8'hB0);
        send(8'h40);
        send(8'h7F);
        check("t3_ctrl", 16'(controller_values), 16'h3FC0);
        check("t3_uv", 16'(update_voice), 16'h0001);
        check("t3_ua", 16'(update_all_voices), 16'h0001);
        check("t3_note_held", 16'(note_values), 16'h205B);
        idle_cycle();
        check("t3_ua_width", 16'(update_all_voices), 16'h0000);

        // 4: realtime interleave, then SysEx skip
        send(8'h90);
        send(8'h3C);
        send(8'hF8);
        check("t4_rt_no_strobe", 16'(update_voice), 16'h0000);
        send(8'h64);
        check("t4_note", 16'(note_values), 16'h323C);
        check("t4_uv", 16'(update_voice), 16'h0001);
        send(8'hF0);
        send(8'h01);
        check("t4_sysex_no_err", 16'(parse_error), 16'h0000);
        send(8'h02);
        send(8'hF7);
        check("t4_sysex_no_uv", 16'(update_voice), 16'h0000);
        send(8'h3C);
        check("t4_perr", 16'(parse_error), 16'h0001);
        check("t4_perr_no_uv", 16'(update_voice), 16'h0000);
        idle_cycle();
        check("t4_perr_width", 16'(parse_error), 16'h0000);

        // 5: channel filter and length-1 message
        send(8'h91);
        send(8'h3C);
        send(8'h64);
        check("t5_ch1_no_uv", 16'(update_voice), 16'h0000);
        check("t5_ch1_note_held", 16'(note_values), 16'h323C);
        send(8'hC0);
        send(8'h05);
        check("t5_pc_no_uv", 16'(update_voice), 16'h0000);
        send(8'h80);
        send(8'h3C);
        send(8'h40);
        check("t5_noteoff", 16'(note_values), 16'h003C);
        check("t5_noteoff_uv", 16'(update_voice), 16'h0001);
        check("t5_ctrl_held", 16'(controller_values), 16'h3FC0);

        // System common F2 swallows two data bytes, the third is an error
        send(8'hF2);
        send(8'h10);
        send(8'h20);
        check("f2_skip_no_err", 16'(parse_error), 16'h0000);
        send(8'h30);
        check("f2_after_skip_err", 16'(parse_error), 16'h0001);

        check("uv_pulse_count", 16'(uv_count), 16'd6);

        // 6: async reset mid-message
        send(8'h90);
        send(8'h3C);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_note", 16'(note_values), 16'h0000);
        check("t6_rst_ctrl", 16'(controller_values), 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        send(8'h64);
        check("t6_perr", 16'(parse_error), 16'h0001);
        check("t6_no_uv", 16'(update_voice), 16'h0000);
        check("t6_note_zero", 16'(note_values), 16'h0000);
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
